ceespu_ex_stage: RTL
====================

Name: ceespu_ex_stage

Overview:
- Execute-stage pipeline controller that wraps the ceespu ALU.
- Holds the ID/EX operand register, drives the ALU operand and opcode ports, and owns the architectural carry flag.
- Sequences multi-cycle (multiply) operations with a stall/ready handshake and registers the result into the EX/WB register.
- Sits between the decode stage (upstream) and writeback (downstream).

Parameters:
- WIDTH, 32, datapath width.
- REGW, 5, destination register index width.
- MUL_OP, 4'd9, ALU opcode that is multi-cycle.

Ports:
- I_clk  in  1  clock.
- I_rst  in  1  synchronous, active-low reset.
- I_valid  in  1  decode presents an op.
- I_aluop  in  4  ALU opcode.
- I_dataA, I_dataB  in  WIDTH  operands.
- I_useCarry  in  1  op consumes the carry flag (adc-type).
- I_setCarry  in  1  op writes the carry flag.
- I_rd  in  REGW  destination register.
- I_writeReg  in  1  op writes the register file.
- I_flush  in  1  kill the ID/EX contents (branch redirect).
- I_stall  in  1  downstream cannot accept.
- O_stall  out  1  upstream must hold its op.
- O_aluA, O_aluB  out  WIDTH  to ALU.
- O_aluop  out  4  to ALU.
- O_aluCin  out  1  to ALU.
- I_aluResult  in  WIDTH  from ALU.
- I_aluCout  in  1  from ALU.
- I_aluDataReady  in  1  multiply result valid.
- O_valid  out  1  EX/WB register holds a live op.
- O_result  out  WIDTH  registered result.
- O_rd  out  REGW  registered destination.
- O_writeReg  out  1  registered write enable (already ANDed with valid).
- O_carry  out  1  architectural carry flag.

Behaviour:
- Reset (I_rst==0 at a clock edge):
  - State goes to EX_IDLE; ID/EX and EX/WB valid bits clear.
  - O_valid=0, O_writeReg=0, O_result=0, O_rd=0, O_carry=0, O_stall=0, O_aluop=0.
  - Reset during a multiply abandons it; the ALU is reset on the same reset net.
- ID/EX load: on an edge with I_valid & !O_stall & !I_flush, latch all inputs and set ex_valid.
- Drive rules:
  - O_aluA/O_aluB come from ID/EX and are held stable for the whole multiply.
  - O_aluop = ex_aluop when ex_valid, else 0 (add), so the ALU multiply counter never ticks while idle.
  - O_aluCin = ex_useCarry & O_carry.
- States:
  - EX_IDLE: no live op.
  - EX_SINGLE: live non-MUL op.
  - EX_MUL: waiting for I_aluDataReady.
  - EX_HOLD: multiply result parked because downstream stalled.
  - EX_KILL: flushed multiply draining.
- Done condition: done = EX_SINGLE, or EX_MUL & I_aluDataReady, or EX_HOLD.
- Advance = done & !I_stall. On advance:
  - EX/WB takes the result (EX_HOLD uses the parked register), rd and writeReg, and O_valid=1.
  - If ex_setCarry, O_carry <= Cout.
  - Next state follows from the new ID/EX load: EX_SINGLE, EX_MUL, or EX_IDLE.
- Latency:
  - Single-cycle op: O_valid rises 1 edge after the ID/EX load.
  - Multiply: O_valid rises on the edge where I_aluDataReady is sampled high.
- EX_MUL & I_aluDataReady & I_stall: park result and Cout in the hold register; go to EX_HOLD; O_aluop goes to 0.
- I_stall with O_valid=1: the EX/WB register holds its value. If nothing advances, O_valid drops to 0 on the next edge (bubble).
- O_stall = ex_valid & !advance, or state==EX_KILL. This is combinational from state, I_stall and I_aluDataReady.
- I_flush:
  - Clears ex_valid for EX_SINGLE and EX_HOLD; the op never reaches EX/WB and O_carry is unchanged.
  - In EX_MUL, go to EX_KILL: O_aluop stays MUL_OP until I_aluDataReady, the result is discarded, then go to EX_IDLE. This keeps the ALU counter consistent.
  - A flush never kills an op already in EX/WB.
- Flush and load on the same edge: the flush wins; the new op is not loaded.
- Carry: a carry produced by op N is visible to op N+1 in the next cycle (back-to-back adc). There is no other bypass.

Decomposition:
- Shared package ceespu_pkg holds:
  - ALU opcode constants (ALU_ADD=0 … ALU_MUL=9).
  - Ex state enum (EX_IDLE, EX_SINGLE, EX_MUL, EX_HOLD, EX_KILL).
  - WIDTH/REGW defaults.
- One natural sub-module: ceespu_ex_ctrl, holding the FSM, done/advance/O_stall logic and flush handling. The top level keeps the datapath registers.

Test Plan:
- Reset held low 3 cycles with I_valid=1 -> O_valid=0, O_carry=0, O_stall=0, O_aluop=0 throughout; first op loads after release.
- Add A=32'hFFFFFFFF, B=1, setCarry=1, then adc A=0, B=0, useCarry=1, back to back -> results 0 then 1; O_carry 1 then 0; O_valid on consecutive cycles; O_stall never high.
- Mul A=7, B=6 with an ALU model giving dataReady on the 3rd cycle -> O_stall high until the ready edge; O_result=42; O_aluA/B stable all cycles; the following op issues next cycle.
- Mul 3×5 with I_stall high when ready arrives, released 2 cycles later -> EX_HOLD entered; O_aluop=0 while holding; O_result=15 after release.
- Flush on the 2nd cycle of a multiply -> no O_valid for it; O_stall stays high until ready, then the next op proceeds; O_carry unchanged.
- Reset low mid-multiply -> next cycle EX_IDLE, O_stall=0, nothing written.

Source files
------------

// File: rtl/ceespu_pkg.sv
// Shared definitions for the ceespu execute stage: ALU opcodes, EX state, widths.
package ceespu_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int REGW_DEF  = 5;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SHL = 4'd5;
   localparam logic [3:0] ALU_SHR = 4'd6;
   localparam logic [3:0] ALU_SRA = 4'd7;
   localparam logic [3:0] ALU_ADC = 4'd8;
   localparam logic [3:0] ALU_MUL = 4'd9;

   typedef enum logic [2:0] {
      EX_IDLE   = 3'd0,
      EX_SINGLE = 3'd1,
      EX_MUL    = 3'd2,
      EX_HOLD   = 3'd3,
      EX_KILL   = 3'd4
   } ex_state_e;

endpackage

// File: rtl/ceespu_ex_ctrl.sv
// EX-stage sequencer: tracks the live op, decides when it completes, when the
// upstream must hold, and how flushes interact with an in-flight multiply.
module ceespu_ex_ctrl
   import ceespu_pkg::*;
(
   input  logic I_clk,
   input  logic I_rst,
   input  logic I_valid,
   input  logic I_isMul,
   input  logic I_flush,
   input  logic I_stall,
   input  logic I_aluDataReady,
   output logic O_load,
   output logic O_wbEn,
   output logic O_park,
   output logic O_fromHold,
   output logic O_aluActive,
   output logic O_stall
);

   ex_state_e state_q, state_d;
   logic      ex_valid, done, advance;
   ex_state_e load_state;

   // State register, synchronous active-low reset abandons any multiply.
   always_ff @(posedge I_clk) begin
      if (!I_rst) state_q <= EX_IDLE;
      else        state_q <= state_d;
   end

   // Handshake, completion and next-state decode.
   always_comb begin
      ex_valid    = (state_q == EX_SINGLE) || (state_q == EX_MUL) || (state_q == EX_HOLD);
      done        = (state_q == EX_SINGLE) || (state_q == EX_HOLD) ||
                    ((state_q == EX_MUL) && I_aluDataReady);
      advance     = done && !I_stall;
      O_stall     = (ex_valid && !advance) || (state_q == EX_KILL);
      O_load      = I_valid && !O_stall && !I_flush;
      // A flush on the completing edge still kills the op before EX/WB.
      O_wbEn      = advance && !I_flush;
      O_park      = (state_q == EX_MUL) && I_aluDataReady && I_stall && !I_flush;
      O_fromHold  = (state_q == EX_HOLD);
      // KILL keeps the multiply opcode so the ALU counter runs to completion.
      O_aluActive = (state_q == EX_SINGLE) || (state_q == EX_MUL) || (state_q == EX_KILL);
      load_state  = O_load ? (I_isMul ? EX_MUL : EX_SINGLE) : EX_IDLE;
      state_d     = state_q;
      case (state_q)
         EX_IDLE:   state_d = load_state;
         EX_SINGLE,
         EX_HOLD:   if (I_flush || advance) state_d = load_state;
         EX_MUL: begin
            if (I_flush)              state_d = I_aluDataReady ? EX_IDLE : EX_KILL;
            else if (advance)         state_d = load_state;
            else if (I_aluDataReady)  state_d = EX_HOLD;
         end
         EX_KILL:   if (I_aluDataReady) state_d = EX_IDLE;
         default:   state_d = EX_IDLE;
      endcase
   end

endmodule

// File: rtl/ceespu_ex_stage.sv
// Execute stage: ID/EX operand register, ALU drive, carry flag, EX/WB register.
module ceespu_ex_stage
   import ceespu_pkg::*;
#(
   parameter int         WIDTH  = WIDTH_DEF,
   parameter int         REGW   = REGW_DEF,
   parameter logic [3:0] MUL_OP = ALU_MUL
) (
   input  logic             I_clk,
   input  logic             I_rst,
   input  logic             I_valid,
   input  logic [3:0]       I_aluop,
   input  logic [WIDTH-1:0] I_dataA,
   input  logic [WIDTH-1:0] I_dataB,
   input  logic             I_useCarry,
   input  logic             I_setCarry,
   input  logic [REGW-1:0]  I_rd,
   input  logic             I_writeReg,
   input  logic             I_flush,
   input  logic             I_stall,
   output logic             O_stall,
   output logic [WIDTH-1:0] O_aluA,
   output logic [WIDTH-1:0] O_aluB,
   output logic [3:0]       O_aluop,
   output logic             O_aluCin,
   input  logic [WIDTH-1:0] I_aluResult,
   input  logic             I_aluCout,
   input  logic             I_aluDataReady,
   output logic             O_valid,
   output logic [WIDTH-1:0] O_result,
   output logic [REGW-1:0]  O_rd,
   output logic             O_writeReg,
   output logic             O_carry
);

   logic             load, wb_en, park, from_hold, alu_active;
   logic [3:0]       ex_aluop_q;
   logic [WIDTH-1:0] ex_a_q, ex_b_q, hold_result_q, wb_result_q;
   logic             ex_useCarry_q, ex_setCarry_q, ex_writeReg_q, hold_cout_q;
   logic [REGW-1:0]  ex_rd_q, wb_rd_q;
   logic             wb_valid_q, wb_writeReg_q, carry_q;
   logic [WIDTH-1:0] res_d;
   logic             cout_d;

   ceespu_ex_ctrl u_ctrl (
      .I_clk          (I_clk),
      .I_rst          (I_rst),
      .I_valid        (I_valid),
      .I_isMul        (I_aluop == MUL_OP),
      .I_flush        (I_flush),
      .I_stall        (I_stall),
      .I_aluDataReady (I_aluDataReady),
      .O_load         (load),
      .O_wbEn         (wb_en),
      .O_park         (park),
      .O_fromHold     (from_hold),
      .O_aluActive    (alu_active),
      .O_stall        (O_stall)
   );

   // ID/EX register: captured only when decode hands over a new op.
   always_ff @(posedge I_clk) begin
      if (!I_rst) begin
         ex_aluop_q    <= '0;
         ex_a_q        <= '0;
         ex_b_q        <= '0;
         ex_useCarry_q <= 1'b0;
         ex_setCarry_q <= 1'b0;
         ex_rd_q       <= '0;
         ex_writeReg_q <= 1'b0;
      end else if (load) begin
         ex_aluop_q    <= I_aluop;
         ex_a_q        <= I_dataA;
         ex_b_q        <= I_dataB;
         ex_useCarry_q <= I_useCarry;
         ex_setCarry_q <= I_setCarry;
         ex_rd_q       <= I_rd;
         ex_writeReg_q <= I_writeReg;
      end
   end

   // Parked multiply result while writeback is stalled.
   always_ff @(posedge I_clk) begin
      if (!I_rst) begin
         hold_result_q <= '0;
         hold_cout_q   <= 1'b0;
      end else if (park) begin
         hold_result_q <= I_aluResult;
         hold_cout_q   <= I_aluCout;
      end
   end

   // Result source: parked value in HOLD, live ALU output otherwise.
   always_comb begin
      res_d  = from_hold ? hold_result_q : I_aluResult;
      cout_d = from_hold ? hold_cout_q   : I_aluCout;
   end

   // EX/WB register and carry flag; data is kept on a bubble, only valid drops.
   always_ff @(posedge I_clk) begin
      if (!I_rst) begin
         wb_valid_q    <= 1'b0;
         wb_result_q   <= '0;
         wb_rd_q       <= '0;
         wb_writeReg_q <= 1'b0;
         carry_q       <= 1'b0;
      end else begin
         wb_valid_q <= wb_en;
         if (wb_en) begin
            wb_result_q   <= res_d;
            wb_rd_q       <= ex_rd_q;
            wb_writeReg_q <= ex_writeReg_q;
            if (ex_setCarry_q) carry_q <= cout_d;
         end
      end
   end

   assign O_aluA     = ex_a_q;
   assign O_aluB     = ex_b_q;
   assign O_aluop    = alu_active ? ex_aluop_q : ALU_ADD;
   assign O_aluCin   = ex_useCarry_q & carry_q;
   assign O_valid    = wb_valid_q;
   assign O_result   = wb_result_q;
   assign O_rd       = wb_rd_q;
   assign O_writeReg = wb_writeReg_q & wb_valid_q;
   assign O_carry    = carry_q;

endmodule
